// File: rtl/mandel_axis_packer.sv
// Mandelbrot raster sink: maps iteration counts to RGB, buffers pixels in a small FIFO,
// and emits an AXI4-Stream video stream with SOF/EOL sideband and a raster-order check.
module mandel_axis_packer #(
    parameter int H_RES      = 1024,
    parameter int V_RES      = 768,
    parameter int ITER_W     = 8,
    parameter int MAX_ITER   = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [ITER_W-1:0] pix_iter,
    output logic [23:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              frame_done,
    output logic              seq_err
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [10:0] X_RES  = 11'(H_RES);
    localparam logic [10:0] Y_RES  = 11'(V_RES);
    localparam logic [10:0] X_LAST = 11'(H_RES - 1);
    localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

    // entry layout: {eof, tuser, tlast, tdata[23:0]}
    logic [26:0]   mem [FIFO_DEPTH];
    logic [26:0]   head;
    logic [26:0]   entry;
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
    logic          empty, full_n, push, pop;
    logic [7:0]    c;
    logic [23:0]   rgb;
    logic          x_in, y_in, x_last, y_last, mismatch;
    logic          tuser_in, tlast_in, eof_in;
    logic [9:0]    ex, ey, ex_n, ey_n;

    generate
        if (ITER_W >= 8) begin : g_iter_wide
            assign c = pix_iter[ITER_W-1 -: 8];
        end else begin : g_iter_narrow
            assign c = {pix_iter, {(8-ITER_W){1'b0}}};
        end
    endgenerate

    always_comb begin
        rgb      = '0;
        if (pix_iter != ITER_W'(MAX_ITER)) begin
            rgb = {c, c[3:0], c[7:4], ~c};
        end
        x_in     = {1'b0, pix_x} < X_RES;
        y_in     = {1'b0, pix_y} < Y_RES;
        x_last   = {1'b0, pix_x} >= X_LAST;
        y_last   = {1'b0, pix_y} >= Y_LAST;
        tuser_in = (pix_x == '0) && (pix_y == '0);
        tlast_in = {1'b0, pix_x} == X_LAST;
        eof_in   = tlast_in && ({1'b0, pix_y} == Y_LAST);
        entry    = {eof_in, tuser_in, tlast_in, rgb};
        mismatch = (pix_x != ex) || (pix_y != ey) || !x_in || !y_in;
    end

    // Successor of the received coordinate; out-of-range values fold back into the raster.
    always_comb begin
        ex_n = '0;
        ey_n = '0;
        if (!y_in) begin
            ex_n = '0;
            ey_n = '0;
        end else if (x_last) begin
            ex_n = '0;
            ey_n = y_last ? '0 : pix_y + 10'd1;
        end else begin
            ex_n = pix_x + 10'd1;
            ey_n = pix_y;
        end
    end

    assign empty  = (wptr == rptr);
    assign push   = pix_valid & pix_ready;
    assign pop    = m_axis_tvalid & m_axis_tready;
    assign wptr_n = wptr + {{AW{1'b0}}, push};
    assign rptr_n = rptr + {{AW{1'b0}}, pop};
    assign full_n = (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= entry;
        end
    end

    // pix_ready is the registered not-full of the next state, so tready never reaches it combinationally.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wptr       <= '0;
            rptr       <= '0;
            pix_ready  <= 1'b0;
            frame_done <= 1'b0;
            seq_err    <= 1'b0;
            ex         <= '0;
            ey         <= '0;
        end else begin
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            pix_ready  <= !full_n;
            frame_done <= pop & head[26];
            if (push) begin
                ex <= ex_n;
                ey <= ey_n;
                if (mismatch) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head[23:0];
    assign m_axis_tuser  = !empty & head[25];
    assign m_axis_tlast  = !empty & head[24];

endmodule

// File: tb/tb_mandel_axis_packer.sv
// Scoreboard bench for mandel_axis_packer on a reduced raster to keep frames short.
module tb_mandel_axis_packer;

    localparam int H = 32;
    localparam int V = 12;
    localparam int N = H * V;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [7:0]  pix_iter = '0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        frame_done;
    logic        seq_err;

    mandel_axis_packer #(
        .H_RES(H),
        .V_RES(V),
        .ITER_W(8),
        .MAX_ITER(255),
        .FIFO_DEPTH(4)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_iter(pix_iter),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done),
        .seq_err(seq_err)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [26:0] sb [$];
    int          mode = 0;     // 0: tready low, 1: tready high, 2: random
    logic        fd_exp = 1'b0;
    int          beats = 0, tuser_cnt = 0, tlast_cnt = 0, fd_cnt = 0;
    logic [23:0] beat5_data = '0, last_tdata = '0;
    logic        tuser_n = 1'b0, last_tuser = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] model(input int x, input int y, input logic [7:0] it);
        logic [23:0] d;
        logic        su, el, ef;
        d  = (it == 8'hFF) ? 24'h000000 : {it, it[3:0], it[7:4], ~it};
        su = (x == 0) && (y == 0);
        el = (x == H - 1);
        ef = el && (y == V - 1);
        return {ef, su, el, d};
    endfunction

    // Output monitor: owns tready, pops the scoreboard on each handshake.
    initial begin
        logic [26:0] e;
        forever begin
            @(negedge aclk);
            if (frame_done || fd_exp) check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            if (frame_done) fd_cnt++;
            case (mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            fd_exp = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {8'd0, m_axis_tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("beat", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, e[25:0]});
                    fd_exp = e[26];
                    if (beats == 5) beat5_data = m_axis_tdata;
                    if (beats == N) tuser_n = m_axis_tuser;
                    if (m_axis_tuser) tuser_cnt++;
                    if (m_axis_tlast) tlast_cnt++;
                    last_tdata = m_axis_tdata;
                    last_tuser = m_axis_tuser;
                    beats++;
                end
            end
        end
    end

    task automatic send(input int x, input int y, input logic [7:0] it);
        int t;
        t = 0;
        pix_x = 10'(x);
        pix_y = 10'(y);
        pix_iter = it;
        pix_valid = 1'b1;
        while (!pix_ready && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        if (!pix_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            pix_valid = 1'b0;
            return;
        end
        sb.push_back(model(x, y, it));
        @(negedge aclk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 4000) begin
            @(negedge aclk);
            t++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        #1;
    endtask

    task automatic set_mode(input int m);
        @(posedge aclk);
        #1 mode = m;
        @(negedge aclk);
    endtask

    task automatic clear_counts();
        beats = 0; tuser_cnt = 0; tlast_cnt = 0; fd_cnt = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        sb.delete();
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_side", {8'd0, m_axis_tuser, m_axis_tlast, frame_done, seq_err, m_axis_tdata[19:0]}, 32'd0);
        check("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel_pix_ready", {31'd0, pix_ready}, 32'd1);
    endtask

    task automatic send_frame();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                send(x, y, 8'(x));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        @(negedge aclk);
        do_reset();

        // full frame, tready always high
        set_mode(1);
        clear_counts();
        send_frame();
        wait_drain();
        check("f1_beats", beats, N);
        check("f1_tuser_cnt", tuser_cnt, 32'd1);
        check("f1_tlast_cnt", tlast_cnt, V);
        check("f1_frame_done", fd_cnt, 32'd1);
        check("f1_seq_err", {31'd0, seq_err}, 32'd0);
        check("f1_pix5", {8'd0, beat5_data}, 32'h0005_50FA);

        // colour map corners
        send(0, 0, 8'hFF);
        wait_drain();
        check("inside_tdata", {8'd0, last_tdata}, 32'd0);
        check("inside_tuser", {31'd0, last_tuser}, 32'd1);
        send(1, 0, 8'h3C);
        wait_drain();
        check("c3c_tdata", {8'd0, last_tdata}, 32'h003C_C3C3);

        // backpressure: fill, hold, release
        set_mode(0);
        send(2, 0, 8'h11);
        send(3, 0, 8'h22);
        send(4, 0, 8'h33);
        check("bp_ready_3", {31'd0, pix_ready}, 32'd1);
        send(5, 0, 8'h44);
        check("bp_ready_full", {31'd0, pix_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_head_stable", {8'd0, m_axis_tdata}, {8'd0, sb[0][23:0]});
        end
        @(posedge aclk);
        #1 mode = 1;
        @(negedge aclk);
        check("bp_ready_before_pop", {31'd0, pix_ready}, 32'd0);
        @(negedge aclk);
        check("bp_ready_after_pop", {31'd0, pix_ready}, 32'd1);
        wait_drain();

        // raster order error
        do_reset();
        clear_counts();
        send(0, 0, 8'h01);
        send(1, 0, 8'h02);
        check("seq_ok", {31'd0, seq_err}, 32'd0);
        send(3, 0, 8'h03);
        check("seq_set", {31'd0, seq_err}, 32'd1);
        send(4, 0, 8'h04);
        check("seq_sticky", {31'd0, seq_err}, 32'd1);
        wait_drain();
        check("seq_beats", beats, 32'd4);
        check("seq_sticky2", {31'd0, seq_err}, 32'd1);

        // two back-to-back frames with random tready
        do_reset();
        set_mode(2);
        clear_counts();
        send_frame();
        send_frame();
        wait_drain();
        check("f2_beats", beats, 2 * N);
        check("f2_frame_done", fd_cnt, 32'd2);
        check("f2_sof2", {31'd0, tuser_n}, 32'd1);
        check("f2_tlast_cnt", tlast_cnt, 2 * V);
        check("f2_seq_err", {31'd0, seq_err}, 32'd0);

        // reset with buffered pixels
        set_mode(0);
        send(0, 0, 8'h10);
        send(1, 0, 8'h20);
        send(2, 0, 8'h30);
        check("mid_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        sb.delete();
        fd_exp = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        set_mode(1);
        clear_counts();
        send(0, 0, 8'h05);
        wait_drain();
        check("post_rst_beats", beats, 32'd1);
        check("post_rst_tuser", {31'd0, last_tuser}, 32'd1);
        check("post_rst_seq", {31'd0, seq_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
